instruction_encoder: RTL and testbench



---
 rtl/alu_pkg.sv | 9 +
 rtl/id_pkg.sv | 114 +++++++++++
 rtl/encoder_fifo.sv | 57 +++++
 rtl/instruction_encoder.sv | 83 ++++++++
 tb/tb_instruction_encoder.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// ALU-side constants shared with the instruction encoder and decoder.
package alu_pkg;

  localparam int unsigned ALU_OPCODE_WIDTH = 3;

  // Opcode 3'b111 is held back for the decoder's pass-through path.
  localparam logic [ALU_OPCODE_WIDTH-1:0] ALU_OP_RESERVED = 3'b111;

endpackage

// File: rtl/id_pkg.sv
// Instruction word layout, opcodes and the request-to-word encoding function.
// The decoder and encoder both use this package.
package id_pkg;

  localparam int unsigned INSTRUCTION_WIDTH = 16;
  localparam int unsigned OPCODE_WIDTH      = 4;
  localparam int unsigned KIND_WIDTH        = 3;
  localparam int unsigned SRC_WIDTH         = 2;
  localparam int unsigned RF_ADDR_WIDTH     = 2;
  localparam int unsigned MEMORY_ADDR_WIDTH = 10;
  localparam int unsigned IMMEDIATE_WIDTH   = 8;

  // Field positions within the instruction word.
  localparam int unsigned OPCODE_LSB      = 0;
  localparam int unsigned SRC_LSB         = 4;
  localparam int unsigned STORE_RF_LSB    = 4;
  localparam int unsigned STORE_MEM_LSB   = 4;
  localparam int unsigned OPERAND_RF_LSB  = 6;
  localparam int unsigned OPERAND_MEM_LSB = 6;
  localparam int unsigned OPERAND_IMM_LSB = 7;

  // ALU opcodes occupy 4'b0xxx; the remaining codes are control instructions.
  typedef enum logic [OPCODE_WIDTH-1:0] {
    I_ADD      = 4'h0,
    I_SUB      = 4'h1,
    I_AND      = 4'h2,
    I_OR       = 4'h3,
    I_XOR      = 4'h4,
    I_SHL      = 4'h5,
    I_SHR      = 4'h6,
    I_PASS     = 4'h7,
    I_LOAD     = 4'h8,
    I_STORERF  = 4'h9,
    I_STOREMEM = 4'hA,
    I_NOP      = 4'hF
  } cpu_instructions;

  typedef enum logic [KIND_WIDTH-1:0] {
    K_ALU      = 3'd0,
    K_LOAD     = 3'd1,
    K_STORERF  = 3'd2,
    K_STOREMEM = 3'd3,
    K_NOP      = 3'd4
  } enc_kind_t;

  localparam logic [SRC_WIDTH-1:0] SRC_REG  = 2'b00;
  localparam logic [SRC_WIDTH-1:0] SRC_MEM  = 2'b01;
  localparam logic [SRC_WIDTH-1:0] SRC_IMM  = 2'b10;
  localparam logic [SRC_WIDTH-1:0] SRC_RSVD = 2'b11;

  typedef struct packed {
    enc_kind_t                          kind;
    logic [alu_pkg::ALU_OPCODE_WIDTH-1:0] alu_op;
    logic [SRC_WIDTH-1:0]               src;
    logic [RF_ADDR_WIDTH-1:0]           rf_addr;
    logic [MEMORY_ADDR_WIDTH-1:0]       mem_addr;
    logic [IMMEDIATE_WIDTH-1:0]         imm;
  } enc_req_t;

  typedef struct packed {
    logic                         illegal;
    logic [INSTRUCTION_WIDTH-1:0] word;
  } enc_result_t;

  localparam logic [INSTRUCTION_WIDTH-1:0] NOP_WORD = INSTRUCTION_WIDTH'(I_NOP);

  // Source-select field plus the operand it selects (ALU and LOAD share this).
  function automatic logic [INSTRUCTION_WIDTH-1:0] operand_bits(input enc_req_t req);
    logic [INSTRUCTION_WIDTH-1:0] w;
    w = '0;
    w[SRC_LSB +: SRC_WIDTH] = req.src;
    case (req.src)
      SRC_REG: w[OPERAND_RF_LSB  +: RF_ADDR_WIDTH]     = req.rf_addr;
      SRC_MEM: w[OPERAND_MEM_LSB +: MEMORY_ADDR_WIDTH] = req.mem_addr;
      SRC_IMM: w[OPERAND_IMM_LSB +: IMMEDIATE_WIDTH]   = req.imm;
      default: w = '0;
    endcase
    return w;
  endfunction

  function automatic enc_result_t encode_instruction(input enc_req_t req);
    enc_result_t res;
    logic [INSTRUCTION_WIDTH-1:0] w;
    logic bad;
    w   = '0;
    bad = 1'b0;
    case (req.kind)
      K_ALU: begin
        bad = (req.src == SRC_RSVD) || (req.alu_op == alu_pkg::ALU_OP_RESERVED);
        w   = operand_bits(req);
        w[OPCODE_LSB +: OPCODE_WIDTH] = {1'b0, req.alu_op};
      end
      K_LOAD: begin
        bad = (req.src == SRC_RSVD);
        w   = operand_bits(req);
        w[OPCODE_LSB +: OPCODE_WIDTH] = I_LOAD;
      end
      K_STORERF: begin
        w[STORE_RF_LSB +: RF_ADDR_WIDTH] = req.rf_addr;
        w[OPCODE_LSB +: OPCODE_WIDTH]    = I_STORERF;
      end
      K_STOREMEM: begin
        w[STORE_MEM_LSB +: MEMORY_ADDR_WIDTH] = req.mem_addr;
        w[OPCODE_LSB +: OPCODE_WIDTH]         = I_STOREMEM;
      end
      K_NOP:   w   = NOP_WORD;
      default: bad = 1'b1;
    endcase
    res.illegal = bad;
    res.word    = bad ? NOP_WORD : w;
    return res;
  endfunction

endpackage

// File: rtl/encoder_fifo.sv
// Generic synchronous FIFO with registered storage; head entry is presented on rdata.
module encoder_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_encoder.sv
// Packs micro-operation requests into 16-bit instruction words and buffers them
// in a small output FIFO; illegal requests become NOP and raise a sticky flag.
module instruction_encoder
  import id_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 2,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [KIND_WIDTH-1:0]                in_kind,
  input  logic [alu_pkg::ALU_OPCODE_WIDTH-1:0] in_alu_op,
  input  logic [SRC_WIDTH-1:0]                 in_src,
  input  logic [RF_ADDR_WIDTH-1:0]             in_rf_addr,
  input  logic [MEMORY_ADDR_WIDTH-1:0]         in_mem_addr,
  input  logic [IMMEDIATE_WIDTH-1:0]           in_imm,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [INSTRUCTION_WIDTH-1:0]         out_instruction,
  output logic                                 err_illegal,
  input  logic                                 err_clr,
  output logic [COUNT_WIDTH-1:0]               instr_count
);

  enc_req_t    req;
  enc_result_t enc;
  logic        accept;
  logic        pop;
  logic        full;
  logic        empty;

  always_comb begin
    req          = '0;
    req.kind     = enc_kind_t'(in_kind);
    req.alu_op   = in_alu_op;
    req.src      = in_src;
    req.rf_addr  = in_rf_addr;
    req.mem_addr = in_mem_addr;
    req.imm      = in_imm;
  end

  assign enc       = encode_instruction(req);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  encoder_fifo #(
    .WIDTH (INSTRUCTION_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .wdata (enc.word),
    .pop   (pop),
    .rdata (out_instruction),
    .full  (full),
    .empty (empty)
  );

  // A new illegal request wins over a clear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_illegal <= 1'b0;
    end else if (accept && enc.illegal) begin
      err_illegal <= 1'b1;
    end else if (err_clr) begin
      err_illegal <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_count <= '0;
    end else if (accept) begin
      instr_count <= instr_count + COUNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Scoreboard bench for instruction_encoder: directed scenarios then random traffic.
module tb_instruction_encoder;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_kind;
  logic [2:0]  in_alu_op;
  logic [1:0]  in_src;
  logic [1:0]  in_rf_addr;
  logic [9:0]  in_mem_addr;
  logic [7:0]  in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instruction;
  logic        err_illegal;
  logic        err_clr;
  logic [15:0] instr_count;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_q[$];
  int          m_count = 0;
  bit          m_err   = 0;

  instruction_encoder #(.FIFO_DEPTH(DEPTH), .COUNT_WIDTH(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_kind         (in_kind),
    .in_alu_op       (in_alu_op),
    .in_src          (in_src),
    .in_rf_addr      (in_rf_addr),
    .in_mem_addr     (in_mem_addr),
    .in_imm          (in_imm),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instruction (out_instruction),
    .err_illegal     (err_illegal),
    .err_clr         (err_clr),
    .instr_count     (instr_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoding built from field values and opcode numbers with plain arithmetic.
  function automatic int ref_word(input int kind, input int alu, input int src,
                                  input int rf, input int mem, input int imm,
                                  output bit illegal);
    int nop, w, operand;
    nop     = int'(id_pkg::I_NOP);
    illegal = 0;
    operand = (src == 0) ? rf * 64 : (src == 1) ? mem * 64 : (src == 2) ? imm * 128 : 0;
    case (kind)
      0: begin illegal = (src == 3) || (alu == 7); w = alu + src * 16 + operand; end
      1: begin illegal = (src == 3); w = int'(id_pkg::I_LOAD) + src * 16 + operand; end
      2: w = int'(id_pkg::I_STORERF) + rf * 16;
      3: w = int'(id_pkg::I_STOREMEM) + mem * 16;
      4: w = nop;
      default: begin illegal = 1; w = nop; end
    endcase
    return illegal ? nop : w;
  endfunction

  // Monitor: compares DUT against the scoreboard each cycle, then applies this cycle's transfers.
  always @(negedge clk) begin
    bit ill;
    int w;
    if (rst) begin
      exp_q.delete();
      m_count = 0;
      m_err   = 0;
    end else begin
      check("in_ready", int'(in_ready), int'(exp_q.size() < DEPTH));
      check("out_valid", int'(out_valid), int'(exp_q.size() != 0));
      check("instr_count", int'(instr_count), m_count % 65536);
      check("err_illegal", int'(err_illegal), int'(m_err));
      if (exp_q.size() != 0) check("out_instruction", int'(out_instruction), int'(exp_q[0]));
      if (out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (in_valid && in_ready) begin
        w = ref_word(int'(in_kind), int'(in_alu_op), int'(in_src), int'(in_rf_addr),
                     int'(in_mem_addr), int'(in_imm), ill);
        exp_q.push_back(16'(w));
        m_count++;
        if (ill) m_err = 1;
        else if (err_clr) m_err = 0;
      end else if (err_clr) begin
        m_err = 0;
      end
    end
  end

  task automatic set_req(input int kind, input int alu, input int src,
                         input int rf, input int mem, input int imm);
    in_kind     = 3'(kind);
    in_alu_op   = 3'(alu);
    in_src      = 2'(src);
    in_rf_addr  = 2'(rf);
    in_mem_addr = 10'(mem);
    in_imm      = 8'(imm);
  endtask

  // Holds a request until accepted; returns #1 after the accepting edge.
  task automatic send(input int kind, input int alu, input int src,
                      input int rf, input int mem, input int imm);
    int budget;
    set_req(kind, alu, src, rf, mem, imm);
    in_valid = 1'b1;
    budget   = 0;
    @(negedge clk);
    while (!in_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", budget);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    set_req(0, 0, 0, 0, 0, 0);
    idle(2);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_instruction", int'(out_instruction), 0);
    check("rst_err_illegal", int'(err_illegal), 0);
    check("rst_instr_count", int'(instr_count), 0);
    rst = 1'b0;
    idle(1);

    // Single-word latency and the documented field placements.
    out_ready = 1'b1;
    send(3, 0, 0, 0, 'h2A5, 0);
    check("storemem_valid", int'(out_valid), 1);
    check("storemem_word", int'(out_instruction), 'h2A5A);
    check("storemem_count", int'(instr_count), 1);
    send(1, 0, 2, 0, 0, 'hC3);
    check("load_imm_word", int'(out_instruction), 'h61A8);
    send(0, 1, 0, 3, 0, 0);
    check("alu_reg_word", int'(out_instruction), 'h00C1);
    idle(2);

    // Back-pressure: two words fill the buffer, the third waits for the drain.
    out_ready = 1'b0;
    send(2, 0, 0, 2, 0, 0);
    send(1, 0, 1, 0, 'h3FF, 0);
    check("full_in_ready", int'(in_ready), 0);
    check("full_head_word", int'(out_instruction), 'h0029);
    fork
      begin
        idle(4);
        out_ready = 1'b1;
      end
    join_none
    send(0, 3, 2, 0, 0, 'h5A);
    idle(4);

    // Sticky illegal flag and clear priority.
    send(0, 7, 0, 1, 0, 0);
    check("illegal_nop_word", int'(out_instruction), 'h000F);
    check("illegal_flag_set", int'(err_illegal), 1);
    idle(3);
    check("illegal_flag_sticky", int'(err_illegal), 1);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    check("illegal_flag_cleared", int'(err_illegal), 0);
    err_clr = 1'b1;
    send(1, 0, 3, 0, 0, 0);
    err_clr = 1'b0;
    check("illegal_beats_clear", int'(err_illegal), 1);
    send(6, 0, 0, 0, 0, 0);
    check("undefined_kind_nop", int'(out_instruction), 'h000F);
    idle(2);

    // Streaming with steady one-entry occupancy across pointer wrap.
    for (int i = 0; i < 8; i++) send(i % 4, i % 7, i % 3, i % 4, i * 37, i * 29);
    idle(3);

    // Asynchronous reset with queued words and a pending request.
    out_ready = 1'b0;
    send(3, 0, 0, 0, 'h111, 0);
    send(3, 0, 0, 0, 'h222, 0);
    set_req(4, 0, 0, 0, 0, 0);
    in_valid = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("async_out_valid", int'(out_valid), 0);
    check("async_instr_count", int'(instr_count), 0);
    check("async_in_ready", int'(in_ready), 1);
    check("async_out_instruction", int'(out_instruction), 0);
    idle(2);
    rst      = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(2);
    check("post_reset_empty", int'(out_valid), 0);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 400; i++) begin
      set_req(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 1023)), int'($urandom_range(0, 255)));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      err_clr   = ($urandom_range(0, 7) == 0);
      idle(1);
    end
    in_valid  = 1'b0;
    err_clr   = 1'b0;
    out_ready = 1'b1;
    idle(4);
    check("final_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
